phy_drv_ctrl: RTL

//  Multi-channel pad-driver controller for the I3C PHY (SCL, SDA, optional extra lanes).

---
 rtl/i3c_phy_pkg.sv | 35 +++
 rtl/phy_drv_chan.sv | 98 +++++++++
 rtl/phy_drv_ctrl.sv | 39 +++
 3 files changed

// File: rtl/i3c_phy_pkg.sv
// Shared types and defaults for the I3C PHY pad-driver control path.
package i3c_phy_pkg;

  typedef enum logic [1:0] {
    DRV_HIZ  = 2'b00,
    DRV_OD   = 2'b01,
    DRV_PP   = 2'b10,
    DRV_RSVD = 2'b11
  } drv_mode_e;

  typedef enum logic [1:0] {
    DRV_OFF  = 2'b00,
    DRV_LO   = 2'b01,
    DRV_HI   = 2'b10,
    DRV_DEAD = 2'b11
  } drv_state_e;

  localparam int DEF_DEAD_CYCLES = 2;

  // Requested pad state for one line; the reserved mode behaves like hi-Z.
  function automatic drv_state_e drv_target(input logic en, input drv_mode_e mode,
                                            input logic data);
    drv_state_e t;
    t = DRV_OFF;
    if (en) begin
      case (mode)
        DRV_OD:  t = data ? DRV_OFF : DRV_LO;
        DRV_PP:  t = data ? DRV_HI : DRV_LO;
        default: t = DRV_OFF;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/phy_drv_chan.sv
// One pad-driver channel: target decode, break-before-make FSM and registered enables.
module phy_drv_chan
  import i3c_phy_pkg::*;
#(
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       data_i,
  output logic       pull_up_en_o,
  output logic       pull_down_en_o,
  output logic       line_o,
  output logic       settled_o
);

  localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

  if (DEAD_CYCLES < 1) begin : g_bad_dead
    $error("phy_drv_chan: DEAD_CYCLES must be >= 1");
  end

  drv_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pu;
  logic             r_pd;
  logic             r_line;
  logic             r_settled;

  drv_state_e       w_target;
  drv_state_e       w_state_next;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_target     = drv_target(en_i, drv_mode_e'(mode_i), data_i);
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      DRV_OFF: begin
        w_state_next = w_target;
        w_cnt_next   = '0;
      end
      DRV_LO: begin
        if (w_target == DRV_HI) begin
          w_state_next = DRV_DEAD;
          w_cnt_next   = CNT_LOAD;
        end else begin
          w_state_next = w_target;
        end
      end
      DRV_HI: begin
        if (w_target == DRV_LO) begin
          w_state_next = DRV_DEAD;
          w_cnt_next   = CNT_LOAD;
        end else begin
          w_state_next = w_target;
        end
      end
      default: begin
        // Release never waits; a drive target only takes effect once the count expires.
        if (w_target == DRV_OFF) begin
          w_state_next = DRV_OFF;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next = w_target;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= DRV_OFF;
      r_cnt     <= '0;
      r_pu      <= 1'b0;
      r_pd      <= 1'b0;
      r_line    <= 1'b1;
      r_settled <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pu      <= (w_state_next == DRV_HI);
      r_pd      <= (w_state_next == DRV_LO);
      r_line    <= (w_state_next != DRV_LO);
      r_settled <= (w_state_next != DRV_DEAD);
    end
  end

  assign pull_up_en_o   = r_pu;
  assign pull_down_en_o = r_pd;
  assign line_o         = r_line;
  assign settled_o      = r_settled;

endmodule

// File: rtl/phy_drv_ctrl.sv
// Multi-channel I3C pad-driver controller: one independent phy_drv_chan per line.
module phy_drv_ctrl
  import i3c_phy_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   data_i,
  output logic [NUM_CH-1:0]   pull_up_en_o,
  output logic [NUM_CH-1:0]   pull_down_en_o,
  output logic [NUM_CH-1:0]   line_o,
  output logic [NUM_CH-1:0]   settled_o
);

  if (NUM_CH < 1) begin : g_bad_num
    $error("phy_drv_ctrl: NUM_CH must be >= 1");
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    phy_drv_chan #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .en_i          (en_i),
      .mode_i        (mode_i[2*gi +: 2]),
      .data_i        (data_i[gi]),
      .pull_up_en_o  (pull_up_en_o[gi]),
      .pull_down_en_o(pull_down_en_o[gi]),
      .line_o        (line_o[gi]),
      .settled_o     (settled_o[gi])
    );
  end

endmodule
